// File: rtl/spi_byte_engine.sv
`timescale 1ns/1ps
// spi_byte_engine: byte-level mode-0 SPI master PHY with chip-select framing and SCLK divider.
// Build option SPI_LOOPBACK_EN: the receive shifter samples spi_mosi internally instead of spi_miso.
module spi_byte_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic       p_clk,
    input  logic       rst,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       busy,
    output logic       spi_sclk,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);
    // state | meaning
    // IDLE  | CS high, ready for the first byte of a frame
    // SETUP | CS low, MOSI holds bit 7, D cycles before the first rising edge
    // SHIFT | eight SCLK periods
    // WAIT  | CS low between bytes, ready for the next byte, no timeout
    // HOLD  | CS low for D cycles after the last falling edge
    // GAP   | CS high for D cycles before returning to IDLE
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] div_q, div_d;
    logic [7:0] tmr_q, tmr_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       last_q, last_d;
    logic       rx_valid_q, rx_valid_d;
    logic       sclk_q, sclk_d;
    logic       mosi_q, mosi_d;
    logic       cs_n_q, cs_n_d;

    logic accept, div_run, wrap, sclk_rise, sclk_fall, byte_done, rx_bit;

`ifdef SPI_LOOPBACK_EN
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_bit      = mosi_q;
`else
    assign rx_bit      = spi_miso;
`endif

    assign tx_ready  = (state_q == IDLE) || (state_q == WAIT);
    assign busy      = (state_q != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign div_run   = (state_q == SETUP) || (state_q == SHIFT);
    assign wrap      = div_run && (div_q == DIV_LAST);
    assign sclk_rise = wrap && !sclk_q;
    assign sclk_fall = wrap && sclk_q;
    assign byte_done = sclk_fall && (bit_cnt_q == 3'd7);

    always_ff @(posedge p_clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, WAIT: if (accept) state_d = SETUP;
            SETUP:      if (wrap) state_d = SHIFT;
            SHIFT:      if (byte_done) state_d = last_q ? HOLD : WAIT;
            HOLD:       if (tmr_q == 8'd0) state_d = GAP;
            GAP:        if (tmr_q == 8'd0) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        div_d = 8'd0;
        if (div_run && !wrap) div_d = div_q + 8'd1;

        // SCLK phase only advances on divider wrap and is forced low outside SETUP/SHIFT
        sclk_d = wrap ? !sclk_q : sclk_q;
        if (!div_run) sclk_d = 1'b0;

        tx_shift_d = tx_shift_q;
        mosi_d     = mosi_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        if (accept) begin
            tx_shift_d = tx_data[6:0];
            mosi_d     = tx_data[7];
            rx_shift_d = 8'd0;
            bit_cnt_d  = 3'd0;
            last_d     = tx_last;
        end
        if (sclk_rise) rx_shift_d = {rx_shift_q[6:0], rx_bit};
        if (sclk_fall) begin
            tx_shift_d = {tx_shift_q[5:0], 1'b0};
            mosi_d     = tx_shift_q[6];
            bit_cnt_d  = bit_cnt_q + 3'd1;
        end

        rx_valid_d = byte_done;
        rx_data_d  = byte_done ? rx_shift_q : rx_data_q;
        cs_n_d     = (state_d == IDLE) || (state_d == GAP);

        tmr_d = tmr_q;
        if ((state_d != state_q) && ((state_d == HOLD) || (state_d == GAP))) begin
            tmr_d = DIV_LAST;
        end else if (tmr_q != 8'd0) begin
            tmr_d = tmr_q - 8'd1;
        end
    end

    always_ff @(posedge p_clk) begin
        if (rst) begin
            div_q      <= 8'd0;
            tmr_q      <= 8'd0;
            bit_cnt_q  <= 3'd0;
            tx_shift_q <= 7'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            last_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            div_q      <= div_d;
            tmr_q      <= tmr_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;
    assign spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
`timescale 1ns/1ps
// Bench for spi_byte_engine: two instances (CLK_DIV=2 and CLK_DIV=1) share one stimulus and
// one SPI slave model; expectations come from the edge-timing formulas of the byte engine.
module tb_spi_byte_engine;
    logic       p_clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       spi_miso;
    logic       sel;

    logic       tx_valid0, tx_ready0, rx_valid0, busy0, sclk0, mosi0, cs_n0;
    logic       tx_valid1, tx_ready1, rx_valid1, busy1, sclk1, mosi1, cs_n1;
    logic [7:0] rx_data0, rx_data1;

    logic       tx_ready_o, rx_valid_o, busy_o, sclk_o, mosi_o, cs_n_o;
    logic [7:0] rx_data_o;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int viol = 0;

    int         rise_cyc[$];
    int         rise_mosi[$];
    int         rxv_cyc[$];
    int         rxv_data[$];
    int         csf_cyc[$];
    int         csr_cyc[$];
    int         rdy_cyc[$];
    logic [7:0] miso_mem[$];

    always #5 p_clk = ~p_clk;
    always @(posedge p_clk) cyc <= cyc + 1;

    assign tx_valid0 = tx_valid && !sel;
    assign tx_valid1 = tx_valid && sel;

    spi_byte_engine #(.CLK_DIV(2)) u_dut2 (
        .p_clk(p_clk), .rst(rst), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid0), .rx_data(rx_data0),
        .busy(busy0), .spi_sclk(sclk0), .spi_mosi(mosi0), .spi_miso(spi_miso), .spi_cs_n(cs_n0)
    );

    spi_byte_engine #(.CLK_DIV(1)) u_dut1 (
        .p_clk(p_clk), .rst(rst), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .tx_data(tx_data), .tx_last(tx_last), .rx_valid(rx_valid1), .rx_data(rx_data1),
        .busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_miso(spi_miso), .spi_cs_n(cs_n1)
    );

    assign tx_ready_o = sel ? tx_ready1 : tx_ready0;
    assign rx_valid_o = sel ? rx_valid1 : rx_valid0;
    assign rx_data_o  = sel ? rx_data1  : rx_data0;
    assign busy_o     = sel ? busy1     : busy0;
    assign sclk_o     = sel ? sclk1     : sclk0;
    assign mosi_o     = sel ? mosi1     : mosi0;
    assign cs_n_o     = sel ? cs_n1     : cs_n0;

    function automatic logic [7:0] exp_rx(input logic [7:0] txb, input logic [7:0] mib);
`ifdef SPI_LOOPBACK_EN
        return txb;
`else
        return mib;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Edge recorder plus mode-0 slave: presents bit 7 on CS fall, next bit after each SCLK fall.
    initial begin : monitor
        logic [7:0] cur;
        logic [2:0] idx;
        int         rd;
        logic       sclk_p, cs_p, rdy_p;
        spi_miso = 1'b0;
        cur = 8'd0; idx = 3'd0; rd = 0;
        sclk_p = 1'b0; cs_p = 1'b1; rdy_p = 1'b1;
        forever begin
            @(negedge p_clk);
            if (sclk_o && !sclk_p) begin
                rise_cyc.push_back(cyc);
                rise_mosi.push_back(int'(mosi_o));
            end
            if (rx_valid_o) begin
                rxv_cyc.push_back(cyc);
                rxv_data.push_back(int'(rx_data_o));
            end
            if (cs_n_o && !cs_p) csr_cyc.push_back(cyc);
            if (!cs_n_o && cs_p) csf_cyc.push_back(cyc);
            if (tx_ready_o && !rdy_p) rdy_cyc.push_back(cyc);
            if (sclk_o && cs_n_o) viol++;
            if (!cs_n_o && cs_p) begin
                if (rd < miso_mem.size()) begin cur = miso_mem[rd]; rd++; end
                else cur = 8'd0;
                idx = 3'd7;
                spi_miso = cur[idx];
            end else if (!cs_n_o && sclk_p && !sclk_o) begin
                if (idx == 3'd0) begin
                    if (tx_ready_o) begin
                        if (rd < miso_mem.size()) begin cur = miso_mem[rd]; rd++; end
                        else cur = 8'd0;
                    end
                    idx = 3'd7;
                end else begin
                    idx = idx - 3'd1;
                end
                spi_miso = cur[idx];
            end
            sclk_p = sclk_o;
            cs_p   = cs_n_o;
            rdy_p  = tx_ready_o;
        end
    end

    task automatic send(input logic [7:0] d, input logic l, output int t);
        int n;
        n = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        tx_last  = l;
        while (!tx_ready_o && n < 2000) begin
            @(negedge p_clk);
            n++;
        end
        check("send_ready_timeout", int'(n < 2000), 1);
        t = cyc;
        @(negedge p_clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        @(negedge p_clk);
        while (busy_o && n < budget) begin
            @(negedge p_clk);
            n++;
        end
        check({tag, "_idle_timeout"}, int'(n < budget), 1);
        @(negedge p_clk);
    endtask

    task automatic wait_rx(input string tag, input int cnt, input int budget);
        int n;
        n = 0;
        while (rxv_cyc.size() < cnt && n < budget) begin
            @(negedge p_clk);
            n++;
        end
        check({tag, "_rx_timeout"}, int'(n < budget), 1);
    endtask

    task automatic check_byte(input string tag, input int t, input int d, input logic [7:0] txb,
                              input logic [7:0] rxb, input int ri, input int vi);
        for (int k = 1; k <= 8; k++) begin
            check({tag, "_rise_cyc"}, rise_cyc[ri+k-1], t + 1 + (2*k - 1)*d);
            check({tag, "_mosi"}, rise_mosi[ri+k-1], int'(txb[3'(8-k)]));
        end
        check({tag, "_rxv_cyc"}, rxv_cyc[vi], t + 1 + 16*d);
        check({tag, "_rx_data"}, rxv_data[vi], int'(rxb));
    endtask

    // Back-to-back frame of n bytes, last flag on the final byte; must start with the engine idle.
    task automatic run_frame(input string tag, input int n, input logic [7:0] txb [8],
                             input logic [7:0] mib [8]);
        int ts [8];
        int r0, v0, cf0, cr0, d;
        d   = sel ? 1 : 2;
        r0  = rise_cyc.size();
        v0  = rxv_cyc.size();
        cf0 = csf_cyc.size();
        cr0 = csr_cyc.size();
        for (int i = 0; i < n; i++) miso_mem.push_back(mib[i]);
        for (int i = 0; i < n; i++) send(txb[i], (i == n - 1), ts[i]);
        wait_idle(tag, 40*d*n + 100);
        for (int i = 0; i < n; i++) begin
            check_byte(tag, ts[i], d, txb[i], exp_rx(txb[i], mib[i]), r0 + 8*i, v0 + i);
        end
        check({tag, "_n_rx"}, rxv_cyc.size() - v0, n);
        check({tag, "_cs_falls"}, csf_cyc.size() - cf0, 1);
        check({tag, "_cs_rises"}, csr_cyc.size() - cr0, 1);
        check({tag, "_cs_rise_cyc"}, csr_cyc[csr_cyc.size()-1], ts[n-1] + 1 + 17*d);
        check({tag, "_ready_cyc"}, rdy_cyc[rdy_cyc.size()-1], ts[n-1] + 1 + 18*d);
        check({tag, "_frame_len"}, rxv_cyc[v0+n-1] - ts[0], n*(16*d + 1));
        check({tag, "_rx_hold"}, int'(rx_data_o), int'(exp_rx(txb[n-1], mib[n-1])));
    endtask

    initial begin : stim
        logic [7:0] ftx [8];
        logic [7:0] fmi [8];
        logic [7:0] a, b, ma, mb;
        int t, t2, r0, v0, cf0, nb, bad_cs, bad_sclk, bad_rdy;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'd0; tx_last = 1'b0; sel = 1'b0;
        repeat (3) @(negedge p_clk);
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            check("rst_cs_n", int'(cs_n_o), 1);
            check("rst_sclk", int'(sclk_o), 0);
            check("rst_mosi", int'(mosi_o), 0);
            check("rst_rx_valid", int'(rx_valid_o), 0);
            check("rst_rx_data", int'(rx_data_o), 0);
            check("rst_busy", int'(busy_o), 0);
            check("rst_tx_ready", int'(tx_ready_o), 1);
        end
        sel = 1'b0;
        @(negedge p_clk);
        rst = 1'b0;
        repeat (2) @(negedge p_clk);

        // single byte, D=2
        ftx[0] = 8'hA5; fmi[0] = 8'h3C;
        run_frame("single_a5", 1, ftx, fmi);

        // flash read frame, back-to-back
        ftx = '{8'h03, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 4; i++) fmi[i] = 8'($urandom);
        fmi[4] = 8'h5A;
        run_frame("flash_read", 5, ftx, fmi);

        // stall in WAIT for 50 cycles
        a = 8'($urandom); b = 8'($urandom); ma = 8'($urandom); mb = 8'($urandom);
        miso_mem.push_back(ma);
        miso_mem.push_back(mb);
        r0 = rise_cyc.size(); v0 = rxv_cyc.size(); cf0 = csf_cyc.size();
        send(a, 1'b0, t);
        wait_rx("stall", v0 + 1, 200);
        bad_cs = 0; bad_sclk = 0; bad_rdy = 0;
        repeat (50) begin
            @(negedge p_clk);
            if (cs_n_o !== 1'b0) bad_cs++;
            if (sclk_o !== 1'b0) bad_sclk++;
            if (tx_ready_o !== 1'b1) bad_rdy++;
        end
        check("stall_cs_low", bad_cs, 0);
        check("stall_sclk_low", bad_sclk, 0);
        check("stall_ready", bad_rdy, 0);
        check("stall_rx_hold", int'(rx_data_o), int'(exp_rx(a, ma)));
        send(b, 1'b1, t2);
        wait_idle("stall", 200);
        check_byte("stall_a", t, 2, a, exp_rx(a, ma), r0, v0);
        check_byte("stall_b", t2, 2, b, exp_rx(b, mb), r0 + 8, v0 + 1);
        check("stall_first_rise", rise_cyc[r0+8] - t2, 1 + 2);
        check("stall_cs_falls", csf_cyc.size() - cf0, 1);

        // reset at the 4th rising edge
        a = 8'($urandom); ma = 8'($urandom);
        miso_mem.push_back(ma);
        v0 = rxv_cyc.size();
        send(a, 1'b1, t);
        while (cyc < t + 1 + 7*2) @(negedge p_clk);
        check("abort_sclk_high", int'(sclk_o), 1);
        rst = 1'b1;
        @(negedge p_clk);
        check("abort_cs_n", int'(cs_n_o), 1);
        check("abort_sclk", int'(sclk_o), 0);
        check("abort_busy", int'(busy_o), 0);
        check("abort_rx_valid", int'(rx_valid_o), 0);
        check("abort_tx_ready", int'(tx_ready_o), 1);
        check("abort_rx_data", int'(rx_data_o), 0);
        rst = 1'b0;
        repeat (40) @(negedge p_clk);
        check("abort_no_rxv", rxv_cyc.size() - v0, 0);
        ftx[0] = 8'($urandom); fmi[0] = 8'($urandom);
        run_frame("after_abort", 1, ftx, fmi);

        // D=1, all ones
        sel = 1'b1;
        ftx[0] = 8'hFF; fmi[0] = 8'($urandom);
        run_frame("div1_ff", 1, ftx, fmi);

        // loopback pattern with MISO held low
        sel = 1'b0;
        ftx[0] = 8'hC3; fmi[0] = 8'h00;
        run_frame("miso_zero_c3", 1, ftx, fmi);

        // random frames on either divider
        for (int f = 0; f < 4; f++) begin
            sel = ($urandom_range(0, 1) == 1);
            nb  = int'($urandom_range(1, 4));
            for (int i = 0; i < 8; i++) begin
                ftx[i] = 8'($urandom);
                fmi[i] = 8'($urandom);
            end
            run_frame("random", nb, ftx, fmi);
        end

        check("sclk_high_with_cs_high", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
